// File: rtl/dcache_pkg.sv
// dcache_pkg
// Shared definitions for the D-cache flush engine:
//   - LINE_W_DEF / ADDR_W_DEF : line and byte-address widths shared by cache and memory
//   - VALID_OFS / DIRTY_OFS   : tag-entry flag positions, counted down from TAG_W
//                               (valid = TAG_W-VALID_OFS, dirty = TAG_W-DIRTY_OFS)
//   - ST_*                    : flush FSM state encoding
//   - line_addr()             : {tag, set, zero offset} line byte-address composition
package dcache_pkg;

  localparam int LINE_W_DEF = 256;
  localparam int ADDR_W_DEF = 32;

  localparam int VALID_OFS = 1;
  localparam int DIRTY_OFS = 2;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] flush_state_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd1;
  localparam logic [2:0] ST_READ      = 3'd2;
  localparam logic [2:0] ST_CHECK     = 3'd3;
  localparam logic [2:0] ST_WB        = 3'd4;
  localparam logic [2:0] ST_CLEAR     = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  // Builds a line byte address from an address tag and set index.
  // Computed at 64 bits; callers truncate to their ADDR_W.
  function automatic logic [63:0] line_addr(input logic [63:0] tag,
                                            input logic [63:0] set,
                                            input int          set_w,
                                            input int          off_w);
    line_addr = ((tag << set_w) | set) << off_w;
  endfunction

endpackage

// File: rtl/dcache_flush_ctrl_wb.sv
// flush_wb_port
// Write-back holding registers and memory handshake for the flush engine.
// Handshake: mem_enable_o/mem_write_o rise on the cycle after start_i and,
// together with mem_addr_o/mem_data_o, stay stable until mem_ack_i is sampled
// high; enable drops on the following cycle. mem_ack_i is ignored while
// enable is low. done_o is the combinational "ack accepted" strobe.
// Ports:
//   Clk, Reset          clock, synchronous active-high reset
//   start_i             capture addr_i/data_i and begin a write
//   addr_i, data_i      line address and data to write back
//   done_o              write accepted this cycle
//   mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, mem_ack_i  memory port
module flush_wb_port #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              done_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i
);

  logic              en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] data_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (start_i) begin
      en_q   <= 1'b1;
      addr_q <= addr_i;
      data_q <= data_i;
    end else if (en_q && mem_ack_i) begin
      en_q   <= 1'b0;
    end
  end

  assign done_o       = en_q & mem_ack_i;
  assign mem_enable_o = en_q;
  assign mem_write_o  = en_q;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = data_q;

endmodule

// File: rtl/dcache_flush_ctrl.sv
// dcache_flush_ctrl
// Data-cache flush engine. On a request it stalls the CPU, waits for the
// cache to go idle, then walks way 0..WAYS-1 / set 0..SETS-1. Each line that
// is both valid and dirty is written back to memory and its dirty bit cleared.
// Completion is a one-cycle flush_done_o pulse; dirty_cnt_o holds the number
// of lines written back until the next flush starts.
// Optional feature macro: DCACHE_FLUSH_AUTO_EN -- one-shot internal flush
// request when a free-running (saturating) cycle counter equals AUTO_CYCLES.
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   flush_req_i, cache_idle_i  request and cache-idle inputs
//   cpu_hold_o, flush_busy_o   high in every state except IDLE
//   flush_done_o, dirty_cnt_o  completion pulse, write-back count
//   sram_set_o, sram_way_o     tag/data SRAM address (read data one cycle later)
//   sram_tag_i, sram_data_i    SRAM read data
//   sram_we_o, sram_tag_o      tag write-back with dirty bit cleared
//   mem_*                      line write port (enable/write/ack handshake)
//   dbg_state_o                current FSM state (ST_* encoding)
module dcache_flush_ctrl
  import dcache_pkg::*;
#(
  parameter int WAYS        = 2,
  parameter int SETS        = 16,
  parameter int TAG_W       = 25,
  parameter int LINE_W      = LINE_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int AUTO_CYCLES = 200
) (
  input  logic                                  Clk,
  input  logic                                  Reset,
  input  logic                                  flush_req_i,
  input  logic                                  cache_idle_i,
  output logic                                  cpu_hold_o,
  output logic                                  flush_busy_o,
  output logic                                  flush_done_o,
  output logic [$clog2(WAYS*SETS):0]            dirty_cnt_o,
  output logic [$clog2(SETS)-1:0]               sram_set_o,
  output logic [(WAYS > 1 ? $clog2(WAYS) : 1)-1:0] sram_way_o,
  input  logic [TAG_W-1:0]                      sram_tag_i,
  input  logic [LINE_W-1:0]                     sram_data_i,
  output logic                                  sram_we_o,
  output logic [TAG_W-1:0]                      sram_tag_o,
  output logic                                  mem_enable_o,
  output logic                                  mem_write_o,
  output logic [ADDR_W-1:0]                     mem_addr_o,
  output logic [LINE_W-1:0]                     mem_data_o,
  input  logic                                  mem_ack_i,
  output logic [STATE_W-1:0]                    dbg_state_o
);

  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CNT_W = $clog2(WAYS*SETS) + 1;
  localparam int OFF_W = $clog2(LINE_W/8);
  localparam int VBIT  = TAG_W - VALID_OFS;
  localparam int DBIT  = TAG_W - DIRTY_OFS;

  flush_state_t      state_q, state_d;
  logic [SET_W-1:0]  set_q;
  logic [WAY_W-1:0]  way_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [TAG_W-1:0]  tag_q;
  logic [TAG_W-1:0]  tag_clr;
  logic              auto_req;
  logic              start_req;
  logic              dirty_hit;
  logic              last_line;
  logic              advance;
  logic              wb_done;
  logic [ADDR_W-1:0] wb_addr;

  // ---------------------------------------------------------------------------
  // Optional auto-flush trigger
  // ---------------------------------------------------------------------------
`ifdef DCACHE_FLUSH_AUTO_EN
  // One bit of headroom so the counter can step past AUTO_CYCLES before saturating.
  localparam int AUTO_W = $clog2(AUTO_CYCLES + 2);
  logic [AUTO_W-1:0] auto_cnt_q;
  logic              auto_fired_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      auto_cnt_q   <= '0;
      auto_fired_q <= 1'b0;
    end else begin
      if (auto_cnt_q != '1) auto_cnt_q <= auto_cnt_q + AUTO_W'(1);
      if (auto_req)         auto_fired_q <= 1'b1;
    end
  end

  // Fires once; if the engine is busy at that moment the request is lost.
  assign auto_req = (auto_cnt_q == AUTO_W'(AUTO_CYCLES)) && !auto_fired_q;
`else
  assign auto_req = 1'b0;
`endif

  assign start_req = flush_req_i | auto_req;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // A line is written only when both valid and dirty; a dirty bit on an
  // invalid line is stale and must not reach memory.
  assign dirty_hit = sram_tag_i[VBIT] & sram_tag_i[DBIT];
  assign last_line = (way_q == WAY_W'(WAYS-1)) && (set_q == SET_W'(SETS-1));
  assign advance   = ((state_q == ST_CHECK) && !dirty_hit) || (state_q == ST_CLEAR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start_req)    state_d = ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (cache_idle_i) state_d = ST_READ;
      ST_READ:                        state_d = ST_CHECK;
      ST_CHECK: begin
        if (dirty_hit)      state_d = ST_WB;
        else if (last_line) state_d = ST_DONE;
        else                state_d = ST_READ;
      end
      ST_WB:        if (wb_done)      state_d = ST_CLEAR;
      ST_CLEAR:     state_d = last_line ? ST_DONE : ST_READ;
      ST_DONE:                        state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      set_q   <= '0;
      way_q   <= '0;
      cnt_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && start_req) begin
        set_q <= '0;
        way_q <= '0;
        cnt_q <= '0;
      end
      if (state_q == ST_CHECK) tag_q <= sram_tag_i;
      if (state_q == ST_CLEAR) cnt_q <= cnt_q + CNT_W'(1);
      // Set index wraps naturally (SETS is a power of two); the way steps on wrap.
      if (advance && !last_line) begin
        set_q <= set_q + SET_W'(1);
        if (set_q == SET_W'(SETS-1)) way_q <= way_q + WAY_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write-back port
  // ---------------------------------------------------------------------------
  assign wb_addr = ADDR_W'(line_addr(64'(sram_tag_i[TAG_W-3:0]), 64'(set_q), SET_W, OFF_W));

  flush_wb_port #(
    .LINE_W (LINE_W),
    .ADDR_W (ADDR_W)
  ) u_wb (
    .Clk          (Clk),
    .Reset        (Reset),
    .start_i      ((state_q == ST_CHECK) && dirty_hit),
    .addr_i       (wb_addr),
    .data_i       (sram_data_i),
    .done_o       (wb_done),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_ack_i    (mem_ack_i)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    tag_clr       = tag_q;
    tag_clr[DBIT] = 1'b0;
  end

  assign cpu_hold_o   = (state_q != ST_IDLE);
  assign flush_busy_o = (state_q != ST_IDLE);
  assign flush_done_o = (state_q == ST_DONE);
  assign dirty_cnt_o  = cnt_q;
  assign sram_set_o   = set_q;
  assign sram_way_o   = way_q;
  assign sram_we_o    = (state_q == ST_CLEAR);
  assign sram_tag_o   = (state_q == ST_CLEAR) ? tag_clr : '0;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// tb_dcache_flush_ctrl
// Directed bench for dcache_flush_ctrl (WAYS=2, SETS=16, TAG_W=25, LINE_W=256).
// A behavioural tag/data SRAM (one-cycle read latency) and a memory responder
// with programmable ack delay surround the DUT; a negedge monitor accumulates
// write-back and tag-write history that the scenario tasks compare against
// hand-computed expectations.
module tb_dcache_flush_ctrl;
  import dcache_pkg::*;

  localparam int WAYS   = 2;
  localparam int SETS   = 16;
  localparam int TAG_W  = 25;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam int NLINES = WAYS * SETS;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  // ---------------- DUT signals ----------------
  logic              flush_req_i = 1'b0;
  logic              cache_idle_i = 1'b1;
  logic              cpu_hold_o, flush_busy_o, flush_done_o;
  logic [5:0]        dirty_cnt_o;
  logic [3:0]        sram_set_o;
  logic [0:0]        sram_way_o;
  logic [TAG_W-1:0]  sram_tag_i;
  logic [LINE_W-1:0] sram_data_i;
  logic              sram_we_o;
  logic [TAG_W-1:0]  sram_tag_o;
  logic              mem_enable_o, mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic              mem_ack_i;
  logic [2:0]        dbg_state_o;

  dcache_flush_ctrl #(
    .WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W), .ADDR_W(ADDR_W), .AUTO_CYCLES(200)
  ) dut (
    .Clk(Clk), .Reset(Reset), .flush_req_i(flush_req_i), .cache_idle_i(cache_idle_i),
    .cpu_hold_o(cpu_hold_o), .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o),
    .dirty_cnt_o(dirty_cnt_o), .sram_set_o(sram_set_o), .sram_way_o(sram_way_o),
    .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_we_o(sram_we_o),
    .sram_tag_o(sram_tag_o), .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- SRAM model ----------------
  logic [TAG_W-1:0]  tag_mem  [NLINES];
  logic [LINE_W-1:0] data_mem [NLINES];

  always @(posedge Clk) begin
    sram_tag_i  <= tag_mem[{sram_way_o, sram_set_o}];
    sram_data_i <= data_mem[{sram_way_o, sram_set_o}];
    if (sram_we_o) tag_mem[{sram_way_o, sram_set_o}] <= sram_tag_o;
  end

  // ---------------- memory responder ----------------
  int   ack_delay = 1;     // enable-high cycles up to and including the ack cycle
  logic ack_force = 1'b0;  // stray ack injection
  int   en_cnt = 0;

  assign mem_ack_i = ack_force | (mem_enable_o && (en_cnt == ack_delay - 1));

  always @(posedge Clk) begin
    if (Reset || !mem_enable_o || mem_ack_i) en_cnt <= 0;
    else                                     en_cnt <= en_cnt + 1;
  end

  // ---------------- monitor ----------------
  int                wb_total = 0, unstable_total = 0, late_drop_total = 0;
  int                done_total = 0, we_total = 0;
  int                en_run = 0, last_en_cycles = 0;
  logic [ADDR_W-1:0] last_addr = '0, prev_addr = '0;
  logic [LINE_W-1:0] last_data = '0, prev_data = '0;
  logic [TAG_W-1:0]  last_we_tag = '0;
  logic [4:0]        last_we_idx = '0;
  logic              prev_en = 1'b0, prev_ack_en = 1'b0;

  always @(negedge Clk) begin
    if (mem_enable_o) begin
      if (mem_write_o !== 1'b1) unstable_total++;
      if (prev_en && (mem_addr_o !== prev_addr || mem_data_o !== prev_data)) unstable_total++;
      en_run++;
      if (mem_ack_i) begin
        wb_total++;
        last_addr      = mem_addr_o;
        last_data      = mem_data_o;
        last_en_cycles = en_run;
        en_run         = 0;
      end
    end else begin
      en_run = 0;
    end
    if (prev_ack_en && mem_enable_o) late_drop_total++;
    if (flush_done_o) done_total++;
    if (sram_we_o) begin
      we_total++;
      last_we_tag = sram_tag_o;
      last_we_idx = {sram_way_o, sram_set_o};
    end
    prev_en     = mem_enable_o && !mem_ack_i;
    prev_ack_en = mem_enable_o && mem_ack_i;
    prev_addr   = mem_addr_o;
    prev_data   = mem_data_o;
  end

  // ---------------- scoreboard counters ----------------
  int errors = 0;
  int checks = 0;

  localparam logic [TAG_W-1:0] TAG_DIRTY = {2'b11, 23'h10};
  localparam logic [TAG_W-1:0] TAG_CLEAN = {2'b10, 23'h10};
  logic [LINE_W-1:0] pat_ecfa;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    Reset        = 1'b1;
    flush_req_i  = 1'b0;
    cache_idle_i = 1'b1;
    ack_force    = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic start_flush();
    @(negedge Clk);
    flush_req_i = 1'b1;
    @(posedge Clk);
    #1 flush_req_i = 1'b0;
  endtask

  // Call right after the request edge: cycle 1 is the first negedge.
  task automatic wait_done(output int cyc, output bit ok, output logic busy_c1);
    cyc = 0; ok = 1'b0; busy_c1 = 1'b0;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge Clk);
      if (i == 1) busy_c1 = flush_busy_o;
      if (flush_done_o) begin
        cyc = i; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic fill_clean();
    @(negedge Clk);
    for (int i = 0; i < NLINES; i++) begin
      tag_mem[i]  <= {1'b1, 1'b0, 23'(i * 3 + 1)};
      data_mem[i] <= {8{$urandom()}};
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge Clk);
    checks++; if (flush_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", flush_busy_o); end
    checks++; if (cpu_hold_o !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b want 0", cpu_hold_o); end
    checks++; if (flush_done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", flush_done_o); end
    checks++; if (dirty_cnt_o !== 6'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", dirty_cnt_o); end
    checks++; if ({mem_enable_o, mem_write_o, sram_we_o} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b want 000", {mem_enable_o, mem_write_o, sram_we_o}); end
    checks++; if (mem_addr_o !== '0 || sram_tag_o !== '0 || sram_set_o !== '0 || sram_way_o !== '0) begin errors++; $display("FAIL reset_buses: addr %h tag %h set %0d way %0d want all 0", mem_addr_o, sram_tag_o, sram_set_o, sram_way_o); end
    checks++; if (dbg_state_o !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state_o, ST_IDLE); end
  endtask

  task automatic test_all_clean();
    int cyc; bit ok; logic b1; int wb0, we0;
    fill_clean();
    wb0 = wb_total; we0 = we_total;
    start_flush();
    wait_done(cyc, ok, b1);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL clean_done_seen: got %b want 1", ok); end
    checks++; if (cyc != 66) begin errors++; $display("FAIL clean_done_cycle: got %0d want 66", cyc); end
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL clean_busy_c1: got %b want 1", b1); end
    checks++; if (wb_total - wb0 != 0) begin errors++; $display("FAIL clean_no_wb: got %0d want 0", wb_total - wb0); end
    checks++; if (we_total - we0 != 0) begin errors++; $display("FAIL clean_no_we: got %0d want 0", we_total - we0); end
    checks++; if (dirty_cnt_o !== 6'd0) begin errors++; $display("FAIL clean_cnt: got %0d want 0", dirty_cnt_o); end
    @(negedge Clk);
    checks++; if (flush_busy_o !== 1'b0 || cpu_hold_o !== 1'b0) begin errors++; $display("FAIL clean_idle_after: busy %b hold %b want 0 0", flush_busy_o, cpu_hold_o); end
  endtask

  task automatic test_single_dirty();
    int cyc; bit ok; logic b1; int wb0, we0, un0;
    @(negedge Clk);
    tag_mem[19]  <= TAG_DIRTY;   // way 1, set 3
    data_mem[19] <= pat_ecfa;
    ack_delay = 1;
    wb0 = wb_total; we0 = we_total; un0 = unstable_total;
    start_flush();
    wait_done(cyc, ok, b1);
    checks++; if (cyc != 68) begin errors++; $display("FAIL dirty_done_cycle: got %0d want 68", cyc); end
    checks++; if (wb_total - wb0 != 1) begin errors++; $display("FAIL dirty_wb_count: got %0d want 1", wb_total - wb0); end
    checks++; if (last_addr !== 32'h0000_2060) begin errors++; $display("FAIL dirty_addr: got %h want 00002060", last_addr); end
    checks++; if (last_data !== pat_ecfa) begin errors++; $display("FAIL dirty_data: got %h want %h", last_data, pat_ecfa); end
    checks++; if (we_total - we0 != 1) begin errors++; $display("FAIL dirty_we_count: got %0d want 1", we_total - we0); end
    checks++; if (last_we_tag !== TAG_CLEAN || last_we_idx !== 5'd19) begin errors++; $display("FAIL dirty_we_tag: got %h@%0d want %h@19", last_we_tag, last_we_idx, TAG_CLEAN); end
    checks++; if (tag_mem[19] !== TAG_CLEAN) begin errors++; $display("FAIL dirty_tag_mem: got %h want %h", tag_mem[19], TAG_CLEAN); end
    checks++; if (dirty_cnt_o !== 6'd1) begin errors++; $display("FAIL dirty_cnt: got %0d want 1", dirty_cnt_o); end
    checks++; if (unstable_total != un0) begin errors++; $display("FAIL dirty_stable: got %0d violations want 0", unstable_total - un0); end
  endtask

  task automatic test_ack_delay();
    int cyc; bit ok; logic b1; int wb0, un0, ld0;
    @(negedge Clk);
    tag_mem[19] <= TAG_DIRTY;
    ack_delay = 10;
    wb0 = wb_total; un0 = unstable_total; ld0 = late_drop_total;
    start_flush();
    wait_done(cyc, ok, b1);
    checks++; if (cyc != 77) begin errors++; $display("FAIL slow_done_cycle: got %0d want 77", cyc); end
    checks++; if (wb_total - wb0 != 1) begin errors++; $display("FAIL slow_wb_count: got %0d want 1", wb_total - wb0); end
    checks++; if (last_en_cycles != 10) begin errors++; $display("FAIL slow_en_cycles: got %0d want 10", last_en_cycles); end
    checks++; if (unstable_total != un0) begin errors++; $display("FAIL slow_stable: got %0d violations want 0", unstable_total - un0); end
    checks++; if (late_drop_total != ld0) begin errors++; $display("FAIL slow_en_drop: got %0d late drops want 0", late_drop_total - ld0); end
    checks++; if (last_addr !== 32'h0000_2060) begin errors++; $display("FAIL slow_addr: got %h want 00002060", last_addr); end
    checks++; if (dirty_cnt_o !== 6'd1) begin errors++; $display("FAIL slow_cnt: got %0d want 1", dirty_cnt_o); end
    ack_delay = 1;
  endtask

  task automatic test_invalid_dirty_idle();
    int cyc; bit ok; logic b1; int wb0, we0;
    @(negedge Clk);
    tag_mem[5] <= {2'b01, 23'h7};   // invalid but dirty
    cache_idle_i = 1'b0;
    wb0 = wb_total; we0 = we_total;
    start_flush();
    for (int i = 1; i <= 5; i++) begin
      @(negedge Clk);
      checks++; if (dbg_state_o !== ST_WAIT_IDLE || cpu_hold_o !== 1'b1) begin errors++; $display("FAIL wait_idle_c%0d: state %0d hold %b want %0d 1", i, dbg_state_o, cpu_hold_o, ST_WAIT_IDLE); end
      if (i == 5) cache_idle_i = 1'b1;
    end
    @(negedge Clk);
    checks++; if (dbg_state_o !== ST_READ) begin errors++; $display("FAIL read_after_idle: got %0d want %0d", dbg_state_o, ST_READ); end
    wait_done(cyc, ok, b1);
    checks++; if (cyc != 64) begin errors++; $display("FAIL inv_done_cycle: got %0d want 64", cyc); end
    checks++; if (wb_total - wb0 != 0 || we_total - we0 != 0) begin errors++; $display("FAIL inv_no_write: wb %0d we %0d want 0 0", wb_total - wb0, we_total - we0); end
    checks++; if (dirty_cnt_o !== 6'd0) begin errors++; $display("FAIL inv_cnt: got %0d want 0", dirty_cnt_o); end
    checks++; if (tag_mem[5] !== {2'b01, 23'h7}) begin errors++; $display("FAIL inv_tag_kept: got %h want %h", tag_mem[5], {2'b01, 23'h7}); end
  endtask

  task automatic test_stray_ack();
    @(negedge Clk);
    ack_force = 1'b1;
    @(negedge Clk);
    checks++; if (mem_enable_o !== 1'b0 || flush_busy_o !== 1'b0 || dbg_state_o !== ST_IDLE) begin errors++; $display("FAIL stray_ack: en %b busy %b state %0d want 0 0 0", mem_enable_o, flush_busy_o, dbg_state_o); end
    ack_force = 1'b0;
  endtask

  task automatic test_reset_mid_wb();
    int cyc; bit ok; logic b1; int wb0, d0; bit seen;
    @(negedge Clk);
    tag_mem[19] <= TAG_DIRTY;
    ack_delay = 1000;
    d0 = done_total;
    start_flush();
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (mem_enable_o) begin seen = 1'b1; break; end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rst_wb_reached: got %b want 1", seen); end
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    checks++; if ({mem_enable_o, flush_busy_o, cpu_hold_o, sram_we_o, flush_done_o} !== 5'b0) begin errors++; $display("FAIL rst_outputs: en/busy/hold/we/done %b want 00000", {mem_enable_o, flush_busy_o, cpu_hold_o, sram_we_o, flush_done_o}); end
    checks++; if (dirty_cnt_o !== 6'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", dirty_cnt_o); end
    @(negedge Clk);
    Reset = 1'b0;
    ack_delay = 1;
    repeat (80) @(negedge Clk);
    checks++; if (done_total != d0) begin errors++; $display("FAIL rst_no_done: got %0d pulses want 0", done_total - d0); end
    checks++; if (tag_mem[19] !== TAG_DIRTY) begin errors++; $display("FAIL rst_dirty_kept: got %h want %h", tag_mem[19], TAG_DIRTY); end
    wb0 = wb_total;
    start_flush();
    wait_done(cyc, ok, b1);
    checks++; if (wb_total - wb0 != 1 || last_addr !== 32'h0000_2060) begin errors++; $display("FAIL rst_rewrite: wb %0d addr %h want 1 00002060", wb_total - wb0, last_addr); end
    checks++; if (dirty_cnt_o !== 6'd1) begin errors++; $display("FAIL rst_rewrite_cnt: got %0d want 1", dirty_cnt_o); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit ok; logic b1;
    @(negedge Clk);
    flush_req_i = 1'b1;
    @(posedge Clk);
    #1;
    wait_done(cyc, ok, b1);
    checks++; if (cyc != 66) begin errors++; $display("FAIL b2b_first_done: got %0d want 66", cyc); end
    @(negedge Clk);
    checks++; if (flush_busy_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got %b want 0", flush_busy_o); end
    @(negedge Clk);
    checks++; if (flush_busy_o !== 1'b1) begin errors++; $display("FAIL b2b_restart: got %b want 1", flush_busy_o); end
    flush_req_i = 1'b0;
    wait_done(cyc, ok, b1);
    checks++; if (cyc != 65) begin errors++; $display("FAIL b2b_second_done: got %0d want 65", cyc); end
  endtask

`ifdef DCACHE_FLUSH_AUTO_EN
  task automatic test_auto();
    int cyc; bit ok; logic b1; int d0;
    // do_reset leaves us in cycle 0 of the counter.
    for (int i = 1; i <= 201; i++) begin
      @(negedge Clk);
      if (i == 200) begin
        checks++; if (flush_busy_o !== 1'b0) begin errors++; $display("FAIL auto_c200: got %b want 0", flush_busy_o); end
      end
      if (i == 201) begin
        checks++; if (flush_busy_o !== 1'b1) begin errors++; $display("FAIL auto_c201: got %b want 1", flush_busy_o); end
      end
    end
    wait_done(cyc, ok, b1);
    d0 = done_total;
    repeat (300) @(negedge Clk);
    checks++; if (done_total != d0) begin errors++; $display("FAIL auto_once: got %0d extra flushes want 0", done_total - d0); end
  endtask
`endif

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] w;
    w = 16'hECFA;
    pat_ecfa = {16{w}};
    for (int i = 0; i < NLINES; i++) begin
      tag_mem[i]  <= '0;
      data_mem[i] <= '0;
    end
    do_reset();
`ifdef DCACHE_FLUSH_AUTO_EN
    fill_clean();
    do_reset();
    test_auto();
`endif
    test_reset();
    test_all_clean();
    test_single_dirty();
    test_ack_delay();
    test_invalid_dirty_idle();
    test_stray_ack();
    test_reset_mid_wb();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/dcache_flush_ctrl.md
# dcache_flush_ctrl

Parametrised data-cache flush engine between the set-associative D-cache tag/data SRAM and the line-wide data memory port. On request it stalls the CPU and waits for the cache to go idle. It then walks every way and set, writes each valid dirty line back to memory over the enable/write/ack handshake, and clears that line's dirty bit. It reports completion and the number of lines written back.

## Interface
- WAYS, 2, associativity, power of two ≥1
- SETS, 16, sets per way, power of two ≥2
- TAG_W, 25, tag entry width; bit TAG_W-1 = valid, bit TAG_W-2 = dirty, bits TAG_W-3:0 = address tag
- LINE_W, 256, line width in bits; OFF_W = log2(LINE_W/8)
- ADDR_W, 32, memory byte-address width; must equal (TAG_W-2)+log2(SETS)+OFF_W
- AUTO_CYCLES, 200, auto-flush trigger cycle (used only with DCACHE_FLUSH_AUTO_EN)
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- flush_req_i  in  1  flush request, sampled only when idle
- cache_idle_i  in  1  cache FSM idle with no miss outstanding
- cpu_hold_o  out  1  stall CPU/cache while flushing
- flush_busy_o  out  1  engine not in IDLE
- flush_done_o  out  1  one-cycle completion pulse
- dirty_cnt_o  out  log2(WAYS*SETS)+1  lines written back by the last flush
- sram_set_o  out  log2(SETS)  read/write set index
- sram_way_o  out  max(1,log2(WAYS))  read/write way
- sram_tag_i  in  TAG_W  tag read data, valid one cycle after address
- sram_data_i  in  LINE_W  line read data, valid one cycle after address
- sram_we_o  out  1  tag write strobe
- sram_tag_o  out  TAG_W  tag write data
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  memory write (always 1 while enabled)
- mem_addr_o  out  ADDR_W  line byte address
- mem_data_o  out  LINE_W  write-back data
- mem_ack_i  in  1  memory acknowledge

## Operation
- States: IDLE, WAIT_IDLE, READ, CHECK, WB, CLEAR, DONE.
- IDLE: when flush_req_i=1, go to WAIT_IDLE; clear dirty_cnt_o; set way=0, set=0.
- WAIT_IDLE: assert cpu_hold_o; go to READ on the first cycle cache_idle_i=1.
- READ: drive sram_set_o/sram_way_o.
- CHECK: latch tag and data. If valid & dirty, go to WB; otherwise advance. A line with valid=0 is never written, regardless of dirty.
- WB: mem_enable_o=1, mem_write_o=1, mem_addr_o={tag[TAG_W-3:0], set, OFF_W'b0}, mem_data_o=latched line. All four are held stable until mem_ack_i=1 is sampled, then go to CLEAR.
- CLEAR: sram_we_o=1 for one cycle, sram_tag_o = latched tag with the dirty bit cleared and valid/tag unchanged. dirty_cnt_o increments. Then advance.
- Advance: set increments; on wrap to 0, way increments. After way WAYS-1 / set SETS-1, go to DONE; otherwise go to READ.
- DONE: flush_done_o=1 for one cycle, then go to IDLE. dirty_cnt_o holds until the next flush starts.
- cpu_hold_o and flush_busy_o are asserted in every state except IDLE.
- flush_req_i is ignored while busy. A request in the DONE cycle is ignored.
- mem_ack_i outside WB is ignored.
- Reset, in any state: next state IDLE. All outputs go to 0 after the edge, including mem_enable_o and sram_we_o. dirty_cnt_o=0. No done pulse. A partially completed write-back is abandoned; its dirty bit stays set.

## Timing
- Reset values: every output 0.
- Clean line costs 2 cycles (READ, CHECK). Dirty line costs 2 + (cycles until ack, ≥1) + 1 (CLEAR).
- All lines clean, cache_idle_i already high, request sampled at edge 0: flush_busy_o high from cycle 1, flush_done_o high at cycle 2·WAYS·SETS+2.
- mem_enable_o drops in the cycle after ack is sampled. There are no back-to-back requests without an intervening non-WB cycle.

## Configuration
- DCACHE_FLUSH_AUTO_EN defined: an internal counter starts at 0 on Reset and increments every Clk cycle. When the counter equals AUTO_CYCLES, a one-shot internal flush request is ORed with flush_req_i. It never retriggers until the next Reset. The counter saturates.
- Not defined: no counter is present; flushes start only from flush_req_i; AUTO_CYCLES has no effect.

## Structure
- Package dcache_pkg holds: the state enum, VALID_BIT/DIRTY_BIT offset constants relative to TAG_W, the line-address composition function, and the shared LINE_W/ADDR_W defaults used by cache and memory.
- One sub-module, flush_wb_port: the WB holding registers plus the enable/ack handshake, with start_i/done_o toward the FSM.

## Test plan
- All 32 lines clean (WAYS=2, SETS=16) -> no mem_enable_o; flush_done_o at cycle 66 after request; dirty_cnt_o=0.
- Way 1 set 3 tag = valid|dirty|23'h10, data = 256'hECFA…ECFA -> exactly one write with mem_addr_o=32'h0000_2060 and that data. Then sram_we_o with the dirty bit cleared; dirty_cnt_o=1.
- Same line, ack delayed 10 cycles -> enable, address and data stable for all 10 cycles; enable low the cycle after ack.
- Line with valid=0, dirty=1 -> no write-back; dirty_cnt_o=0. cache_idle_i held low 5 cycles -> READ starts the cycle after it rises.
- Reset asserted mid-WB -> mem_enable_o, flush_busy_o and cpu_hold_o low after the edge; no flush_done_o; a later flush writes the line again.
- With DCACHE_FLUSH_AUTO_EN, AUTO_CYCLES=200 -> flush_busy_o rises at cycle 201 without flush_req_i; there is no second auto flush.
